// File: rtl/instr_mem_loadable_pkg.sv
// Shared types and constants for the miniMips instruction memory.
package minimips_pkg;

  // Sequencer states: array fill, normal fetch, in-system program load.
  typedef enum logic [1:0] {
    IM_CLEAR = 2'd0,
    IM_RUN   = 2'd1,
    IM_LOAD  = 2'd2
  } im_state_t;

  // Default geometry of the instruction store.
  localparam int IM_AW_DEFAULT = 8;
  localparam int IM_DW_DEFAULT = 9;

  // Fill instruction, also presented on fetch whenever the array is not valid.
  localparam logic [IM_DW_DEFAULT-1:0] NO_OP_INSTR = 9'b101100100;

  // Number of entries for a given address width.
  function automatic int im_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Fetch port plus program-load stream of the instruction memory.
// master = fetch stage / boot loader side, slave = the memory.
interface instr_mem_loadable_if #(
  parameter int AW = 8,
  parameter int DW = 9
);
  // Fetch side
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic          mem_ready;
  // Control
  logic          clear_req;
  logic          load_start;
  // Load stream
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  // Load status
  logic          load_done;
  logic [AW:0]   load_count;
  logic          load_ovf;

  modport master (
    output pc, clear_req, load_start, load_valid, load_data, load_last,
    input  instr, mem_ready, load_ready, load_done, load_count, load_ovf
  );

  modport slave (
    input  pc, clear_req, load_start, load_valid, load_data, load_last,
    output instr, mem_ready, load_ready, load_done, load_count, load_ovf
  );
endinterface

// File: rtl/instr_mem_loadable_imem_array.sv
// DEPTH x DW storage with one synchronous write port and one combinational
// read port, kept separate so it can later be mapped onto block RAM.
module imem_array #(
  parameter int AW = 8,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] core_q [2**AW];

  // Single write port.
  // NOTE: the array has no reset on purpose; a reset on every entry would block
  // RAM inference, and the clear sequencer in the parent rewrites every word anyway.
  always_ff @(posedge clk) begin
    if (we_i) begin
      core_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = core_q[raddr_i];

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the miniMips core: combinational fetch,
// NO_OP clear sequencer after reset / on request, and an auto-incrementing
// valid/ready program-load port.
module instr_mem_loadable
  import minimips_pkg::*;
#(
  parameter int            AW    = IM_AW_DEFAULT,
  parameter int            DW    = IM_DW_DEFAULT,
  parameter logic [DW-1:0] NO_OP = DW'(NO_OP_INSTR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_mem_loadable_if.slave  bus
);

  localparam int            DEPTH     = im_depth(AW);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  im_state_t     state_q,      state_d;
  logic [AW-1:0] clr_addr_q,   clr_addr_d;
  logic [AW-1:0] wr_addr_q,    wr_addr_d;
  logic [AW:0]   load_count_q, load_count_d;
  logic          load_ovf_q,   load_ovf_d;
  logic          load_done_q,  load_done_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  // State and counter registers; the array itself is never reset.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IM_CLEAR;
      clr_addr_q   <= '0;
      wr_addr_q    <= '0;
      load_count_q <= '0;
      load_ovf_q   <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      wr_addr_q    <= wr_addr_d;
      load_count_q <= load_count_d;
      load_ovf_q   <= load_ovf_d;
      load_done_q  <= load_done_d;
    end
  end

  // Next-state logic and the single write port mux (CLEAR and LOAD never overlap).
  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    wr_addr_d    = wr_addr_q;
    load_count_d = load_count_q;
    load_ovf_d   = load_ovf_q;
    load_done_d  = 1'b0;
    we           = 1'b0;
    waddr        = clr_addr_q;
    wdata        = NO_OP;

    unique case (state_q)
      IM_CLEAR: begin
        // One NO_OP per cycle; clr_addr wraps back to 0 on the final word.
        we         = 1'b1;
        waddr      = clr_addr_q;
        wdata      = NO_OP;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = IM_RUN;
        end
      end

      IM_RUN: begin
        if (bus.clear_req) begin
          state_d    = IM_CLEAR;
          clr_addr_d = '0;
          load_ovf_d = 1'b0;
        end else if (bus.load_start) begin
          state_d    = IM_LOAD;
          wr_addr_d  = '0;
          load_ovf_d = 1'b0;
        end
      end

      IM_LOAD: begin
        if (bus.clear_req) begin
          // Abort: no load_done, the whole array is refilled.
          state_d    = IM_CLEAR;
          clr_addr_d = '0;
          load_ovf_d = 1'b0;
        end else if (bus.load_start) begin
          // Restart the program at address 0; a beat in this cycle is dropped.
          wr_addr_d = '0;
        end else if (bus.load_valid) begin
          we    = 1'b1;
          waddr = wr_addr_q;
          wdata = bus.load_data;
          if (bus.load_last || (wr_addr_q == LAST_ADDR)) begin
            // Final word, or array full: leave without wrapping wr_addr.
            state_d      = IM_RUN;
            load_count_d = {1'b0, wr_addr_q} + {{AW{1'b0}}, 1'b1};
            load_ovf_d   = !bus.load_last;
            load_done_d  = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = IM_CLEAR;
      end
    endcase
  end

  imem_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (bus.pc),
    .rdata_o (rdata)
  );

  // Outside RUN the core only ever sees NO_OP, whatever pc is.
  assign bus.mem_ready  = (state_q == IM_RUN);
  assign bus.instr      = bus.mem_ready ? rdata : NO_OP;
  assign bus.load_ready = (state_q == IM_LOAD);
  assign bus.load_done  = load_done_q;
  assign bus.load_count = load_count_q;
  assign bus.load_ovf   = load_ovf_q;

endmodule
